// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the two-requester APB GPIO master.
// The GPIO peripheral exposes a direction register and a data register.
package apb_gpio_pkg;

    localparam int STRB_W = 4;

    localparam logic [31:0] GPIO_DIR_ADDR  = 32'h0000_0000;
    localparam logic [31:0] GPIO_DATA_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Reads must present an all-zero strobe on the bus.
    function automatic logic [STRB_W-1:0] apb_strb(input logic write,
                                                   input logic [STRB_W-1:0] strb);
        return write ? strb : '0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant flop only moves when a
// request is actually accepted, so an idle bus never shifts priority.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        case (i_req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/apb_gpio_master_arb.sv
// APB master shared by two requesters: round-robin accept, IDLE/SETUP/ACCESS
// sequencing with PREADY wait states, per-requester response pulse, timeout abort.
module apb_gpio_master_arb
    import apb_gpio_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [STRB_W-1:0] req0_strb,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [STRB_W-1:0] req1_strb,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [STRB_W-1:0] PSTRB,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        r_state;
    apb_state_e        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [STRB_W-1:0] r_pstrb;
    logic [DATA_W-1:0] r_pwdata;

    logic [1:0]        w_grant;
    logic [1:0]        w_ready;
    logic              w_accept;
    logic              w_done;
    logic              w_abort;

    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [STRB_W-1:0] w_sel_strb;

    logic [1:0]        r_rsp_valid;
    logic [1:0]        r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata [2];

    rr_arb2 u_arb (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETn),
        .i_req    ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_sel_write = w_grant[1] ? req1_write : req0_write;
    assign w_sel_addr  = w_grant[1] ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant[1] ? req1_wdata : req0_wdata;
    assign w_sel_strb  = w_grant[1] ? req1_strb  : req0_strb;

    always_comb begin
        w_state_next = r_state;
        w_ready      = 2'b00;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is withheld while reset is asserted so nothing is acknowledged.
                if (PRESETn) begin
                    w_ready = w_grant;
                    if (|w_grant) begin
                        w_state_next = SETUP;
                    end
                end
            end
            SETUP: w_state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept   = |w_ready;
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pstrb   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_psel   <= 1'b1;
                        r_paddr  <= w_sel_addr;
                        r_pwrite <= w_sel_write;
                        r_pwdata <= w_sel_wdata;
                        r_pstrb  <= apb_strb(w_sel_write, w_sel_strb);
                        r_owner  <= w_grant[1];
                        r_cnt    <= '0;
                    end
                end
                SETUP: r_penable <= 1'b1;
                ACCESS: begin
                    // Address/data deliberately keep their last values after completion.
                    if (w_done || w_abort) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        always_ff @(posedge PCLK) begin
            if (!PRESETn) begin
                r_rsp_valid[gi] <= 1'b0;
                r_rsp_err[gi]   <= 1'b0;
                r_rsp_rdata[gi] <= '0;
            end else if ((w_done || w_abort) && (r_owner == 1'(gi))) begin
                r_rsp_valid[gi] <= 1'b1;
                r_rsp_err[gi]   <= w_abort;
                r_rsp_rdata[gi] <= (w_done && !r_pwrite) ? PRDATA : '0;
            end else begin
                r_rsp_valid[gi] <= 1'b0;
                r_rsp_err[gi]   <= 1'b0;
                r_rsp_rdata[gi] <= '0;
            end
        end
    end

    assign rsp0_valid = r_rsp_valid[0];
    assign rsp0_err   = r_rsp_err[0];
    assign rsp0_rdata = r_rsp_rdata[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp1_err   = r_rsp_err[1];
    assign rsp1_rdata = r_rsp_rdata[1];

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PADDR   = r_paddr;
    assign PWRITE  = r_pwrite;
    assign PSTRB   = r_pstrb;
    assign PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_gpio_master_arb.sv
// Bench for apb_gpio_master_arb: a GPIO slave with programmable wait states
// plus a register/arbitration reference model that predicts every response.
module tb_apb_gpio_master_arb;
    import apb_gpio_pkg::*;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_strb;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_strb;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: GPIO register contents and who won the last accept.
    logic [31:0] m_dir  = 32'h0;
    logic [31:0] m_data = 32'h0;
    int          m_last = 1;

    // Slave: ready after slave_wait ACCESS cycles; negative = never ready.
    int          slave_wait = 0;
    int          s_cnt = 0;
    logic [31:0] s_dir = 32'h0;
    logic [31:0] s_data = 32'h0;

    typedef struct {
        int          acc;
        logic        setup_ok;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pwrite;
        logic        got;
        logic        other;
        logic [31:0] rd;
        logic        er;
        logic        once;
    } obs_t;

    apb_gpio_master_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign PREADY = PSEL && PENABLE && (slave_wait >= 0) && (s_cnt >= slave_wait);
    assign PRDATA = (PADDR == GPIO_DATA_ADDR) ? s_data : s_dir;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY) begin
            s_cnt <= 0;
            if (PWRITE) begin
                if (PADDR == GPIO_DATA_ADDR) s_data <= merge(s_data, PWDATA, PSTRB);
                else                         s_dir  <= merge(s_dir, PWDATA, PSTRB);
            end
        end else if (PSEL && PENABLE) begin
            s_cnt <= s_cnt + 1;
        end else begin
            s_cnt <= 0;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return (a == GPIO_DATA_ADDR) ? m_data : m_dir;
    endfunction

    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] s);
        if (w) begin
            if (a == GPIO_DATA_ADDR) m_data = merge(m_data, wd, s);
            else                     m_dir  = merge(m_dir, wd, s);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] s);
        if (n == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = wd; req0_strb = s;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = wd; req1_strb = s;
        end
    endtask

    // Drives one request from requester n and records what the bus and response did.
    task automatic run_xfer(input int n, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s, output obs_t o);
        bit acc_ok;
        o = '{default: 0};
        acc_ok = 0;
        @(negedge PCLK);
        set_req(n, 1'b1, w, a, wd, s);
        for (int k = 0; k < 50; k++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                acc_ok = 1;
                break;
            end
            @(negedge PCLK);
        end
        tests_run++;
        if (!acc_ok) begin
            tests_failed++;
            $display("FAIL accept_timeout req%0d: ready=0 required=1", n);
            set_req(n, 1'b0, w, a, wd, s);
            return;
        end
        m_last = n;
        @(posedge PCLK);
        @(negedge PCLK);
        set_req(n, 1'b0, w, a, wd, s);
        o.setup_ok = PSEL && !PENABLE;
        o.paddr    = PADDR;
        o.pwdata   = PWDATA;
        o.pstrb    = PSTRB;
        o.pwrite   = PWRITE;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) o.acc++;
            else break;
        end
        o.got   = (n == 0) ? rsp0_valid : rsp1_valid;
        o.other = (n == 0) ? rsp1_valid : rsp0_valid;
        o.rd    = (n == 0) ? rsp0_rdata : rsp1_rdata;
        o.er    = (n == 0) ? rsp0_err : rsp1_err;
        @(negedge PCLK);
        o.once  = !((n == 0) ? rsp0_valid : rsp1_valid);
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF);
        set_req(1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA, rsp0_valid, rsp1_valid,
             rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: psel=%b pen=%b paddr=%h pwdata=%h rsp=%b%b required all 0",
                     PSEL, PENABLE, PADDR, PWDATA, rsp0_valid, rsp1_valid);
        end
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready: ready=%b%b required 00", req1_ready, req0_ready);
        end
        PRESETn = 1'b1;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_first_tie: ready={%b,%b} required {0,1}", req1_ready, req0_ready);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m_last = 1;
        $display("[TB] reset: outputs cleared, first tie offered to req0");
    endtask

    task automatic test_write_dir();
        obs_t o;
        slave_wait = 0;
        run_xfer(0, 1'b1, GPIO_DIR_ADDR, 32'hAF78_CF55, 4'b0001, o);
        model_apply(1'b1, GPIO_DIR_ADDR, 32'hAF78_CF55, 4'b0001);
        $display("[TB] write dir: acc=%0d rsp=%b err=%b rdata=%h", o.acc, o.got, o.er, o.rd);
        tests_run++;
        if (!o.setup_ok || o.acc != 1) begin
            tests_failed++;
            $display("FAIL wr_phases: setup_ok=%b access=%0d required 1/1", o.setup_ok, o.acc);
        end
        tests_run++;
        if (o.paddr !== GPIO_DIR_ADDR || o.pstrb !== 4'b0001 || o.pwdata !== 32'hAF78_CF55 || o.pwrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_bus: paddr=%h pstrb=%b pwdata=%h pwrite=%b required 00000000/0001/af78cf55/1",
                     o.paddr, o.pstrb, o.pwdata, o.pwrite);
        end
        tests_run++;
        if (!o.got || o.er !== 1'b0 || o.rd !== 32'h0 || !o.once || o.other) begin
            tests_failed++;
            $display("FAIL wr_rsp: valid=%b err=%b rdata=%h once=%b other=%b required 1/0/0/1/0",
                     o.got, o.er, o.rd, o.once, o.other);
        end
        tests_run++;
        if (s_dir[7:0] !== 8'h55 || s_dir !== m_dir) begin
            tests_failed++;
            $display("FAIL wr_gpio_dir: dir=%h required %h", s_dir, m_dir);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        slave_wait = 0;
        run_xfer(1, 1'b1, GPIO_DATA_ADDR, 32'h0000_000A, 4'hF, o);
        model_apply(1'b1, GPIO_DATA_ADDR, 32'h0000_000A, 4'hF);
        slave_wait = 3;
        run_xfer(1, 1'b0, GPIO_DATA_ADDR, 32'hDEAD_BEEF, 4'hF, o);
        slave_wait = 0;
        $display("[TB] read data wait3: acc=%0d pstrb=%b rdata=%h err=%b", o.acc, o.pstrb, o.rd, o.er);
        tests_run++;
        if (o.acc != 4 || !o.setup_ok) begin
            tests_failed++;
            $display("FAIL rd_wait_penable: access=%0d required 4", o.acc);
        end
        tests_run++;
        if (o.pstrb !== 4'b0000 || o.pwrite !== 1'b0 || o.paddr !== GPIO_DATA_ADDR) begin
            tests_failed++;
            $display("FAIL rd_bus: pstrb=%b pwrite=%b paddr=%h required 0000/0/ffffffff", o.pstrb, o.pwrite, o.paddr);
        end
        tests_run++;
        if (!o.got || o.rd !== model_read(GPIO_DATA_ADDR) || o.er !== 1'b0 || !o.once) begin
            tests_failed++;
            $display("FAIL rd_rsp: valid=%b rdata=%h err=%b required 1/%h/0", o.got, o.rd, o.er,
                     model_read(GPIO_DATA_ADDR));
        end
    endtask

    task automatic test_back_to_back();
        int who[$];
        int when[$];
        int exp_g;
        bit both;
        slave_wait = 0;
        both = 0;
        @(negedge PCLK);
        set_req(0, 1'b1, 1'b1, GPIO_DIR_ADDR, 32'h0000_00C3, 4'b0001);
        set_req(1, 1'b1, 1'b0, GPIO_DATA_ADDR, 32'h0, 4'h0);
        for (int i = 0; i <= 12; i++) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready) begin who.push_back(0); when.push_back(i); end
            else if (req1_ready) begin who.push_back(1); when.push_back(i); end
            @(negedge PCLK);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) @(negedge PCLK);
        tests_run++;
        if (both || who.size() < 4) begin
            tests_failed++;
            $display("FAIL b2b_grants: both_ready=%b grants=%0d required 0/>=4", both, who.size());
        end else begin
            exp_g = (m_last == 1) ? 0 : 1;
            for (int k = 0; k < 4; k++) begin
                $display("[TB] b2b grant %0d: req%0d at cycle %0d", k, who[k], when[k]);
                tests_run++;
                if (who[k] != exp_g || (k > 0 && when[k] - when[k-1] != 3)) begin
                    tests_failed++;
                    $display("FAIL b2b_order[%0d]: req%0d gap=%0d required req%0d gap=3", k, who[k],
                             (k > 0) ? when[k] - when[k-1] : 3, exp_g);
                end
                exp_g = 1 - exp_g;
            end
            m_last = who[who.size()-1];
            model_apply(1'b1, GPIO_DIR_ADDR, 32'h0000_00C3, 4'b0001);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        slave_wait = -1;
        run_xfer(1, 1'b0, GPIO_DIR_ADDR, 32'h0, 4'h0, o);
        slave_wait = 0;
        $display("[TB] timeout read: acc=%0d err=%b rdata=%h", o.acc, o.er, o.rd);
        tests_run++;
        if (o.acc != TIMEOUT) begin
            tests_failed++;
            $display("FAIL to_access_len: access=%0d required %0d", o.acc, TIMEOUT);
        end
        tests_run++;
        if (!o.got || o.er !== 1'b1 || o.rd !== 32'h0 || !o.once) begin
            tests_failed++;
            $display("FAIL to_rsp: valid=%b err=%b rdata=%h required 1/1/0", o.got, o.er, o.rd);
        end
        run_xfer(0, 1'b0, GPIO_DIR_ADDR, 32'h0, 4'h0, o);
        $display("[TB] post-timeout read: acc=%0d err=%b rdata=%h", o.acc, o.er, o.rd);
        tests_run++;
        if (o.acc != 1 || !o.got || o.er !== 1'b0 || o.rd !== model_read(GPIO_DIR_ADDR)) begin
            tests_failed++;
            $display("FAIL to_recover: access=%0d valid=%b err=%b rdata=%h required 1/1/0/%h",
                     o.acc, o.got, o.er, o.rd, model_read(GPIO_DIR_ADDR));
        end
    endtask

    task automatic test_random();
        obs_t o;
        int n, wt;
        logic w;
        logic [31:0] a, wd, exp_rd;
        logic [3:0] s;
        for (int t = 0; t < 20; t++) begin
            n  = $urandom_range(1, 0);
            w  = 1'($urandom_range(1, 0));
            a  = $urandom_range(1, 0) ? GPIO_DATA_ADDR : GPIO_DIR_ADDR;
            wd = $urandom;
            s  = 4'($urandom);
            wt = $urandom_range(3, 0);
            slave_wait = wt;
            exp_rd = w ? 32'h0 : model_read(a);
            run_xfer(n, w, a, wd, s, o);
            model_apply(w, a, wd, s);
            $display("[TB] rand %0d: req%0d %s addr=%h wdata=%h strb=%b wait=%0d -> acc=%0d rdata=%h err=%b",
                     t, n, w ? "WR" : "RD", a, wd, s, wt, o.acc, o.rd, o.er);
            tests_run++;
            if (o.acc != wt + 1 || o.paddr !== a || o.pstrb !== (w ? s : 4'h0) || o.pwrite !== w) begin
                tests_failed++;
                $display("FAIL rand_bus[%0d]: acc=%0d paddr=%h pstrb=%b required %0d/%h/%b", t, o.acc,
                         o.paddr, o.pstrb, wt + 1, a, w ? s : 4'h0);
            end
            tests_run++;
            if (!o.got || o.other || o.rd !== exp_rd || o.er !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_rsp[%0d]: valid=%b other=%b rdata=%h err=%b required 1/0/%h/0", t,
                         o.got, o.other, o.rd, o.er, exp_rd);
            end
        end
        slave_wait = 0;
    endtask

    task automatic test_reset_mid();
        bit saw_rsp;
        saw_rsp = 0;
        slave_wait = -1;
        @(negedge PCLK);
        set_req(1, 1'b1, 1'b1, GPIO_DIR_ADDR, 32'hFFFF_FFFF, 4'hF);
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_accept: ready1=%b required 1", req1_ready);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b0;
        set_req(0, 1'b1, 1'b0, GPIO_DIR_ADDR, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, GPIO_DATA_ADDR, 32'h0, 4'h0);
        for (int e = 0; e < 2; e++) begin
            @(negedge PCLK);
            if (rsp0_valid || rsp1_valid) saw_rsp = 1;
            tests_run++;
            if ({PSEL, PENABLE, req0_ready, req1_ready} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rstmid_bus[%0d]: psel=%b pen=%b ready=%b%b required 0000", e, PSEL, PENABLE,
                         req0_ready, req1_ready);
            end
        end
        PRESETn = 1'b1;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstmid_tie: ready={%b,%b} required {0,1}", req1_ready, req0_ready);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        m_last = 1;
        slave_wait = 0;
        repeat (2) begin
            @(negedge PCLK);
            if (rsp0_valid || rsp1_valid) saw_rsp = 1;
        end
        tests_run++;
        if (saw_rsp || s_dir !== m_dir) begin
            tests_failed++;
            $display("FAIL rstmid_norsp: rsp_seen=%b dir=%h required 0/%h", saw_rsp, s_dir, m_dir);
        end
        $display("[TB] reset during ACCESS: bus dropped, no response, req0 offered first");
    endtask

    initial begin
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        PRESETn = 1'b0;
        test_reset();
        test_write_dir();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        test_write_dir();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
